uart_tx_engine: RTL

Parametrised UART transmit engine: accepts a parallel word on a start/ready handshake and serialises it as start bit, data bits LSB-first, optional parity bit and 1–2 stop bits. Each bit lasts OVERSAMPLE Baud_Clk cycles. It supersedes the fixed-frame transmitter controller by owning its own shift register, bit timing and registered serial line. It sits between the host-side TX buffer and the pad.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx_engine.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE       = 3'b000,
    TX_START_BIT  = 3'b001,
    TX_DATA_BIT   = 3'b010,
    TX_PARITY_BIT = 3'b011,
    TX_STOP_BIT   = 3'b100
  } tx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;
  localparam int OVERSAMPLE_MIN = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1, flags the last tick of a bit,
// and restarts from zero whenever i_clear is high.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_tick;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else if (i_clear || o_bit_end) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + CNT_W'(1);
    end
  end

  assign o_bit_end = (r_tick == LAST_TICK);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Parity stage is present only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Baud_Clk,
  input  logic                 Reset,
  input  logic                 Tx_start,
  input  logic [DATA_BITS-1:0] Tx_data,
  input  logic                 Parity_odd,
  output logic                 Tx_ready,
  output logic                 Tx_busy,
  output logic                 Tx_done,
  output logic                 Tx_serial
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      OVERSAMPLE < OVERSAMPLE_MIN) begin : g_param_check
    $error("uart_tx_engine: illegal DATA_BITS, STOP_BITS or OVERSAMPLE");
  end

  tx_state_t            r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic                 r_stop_cnt, w_stop_cnt_next;
  logic                 r_serial, w_serial_next;
  logic                 w_bit_end;
  logic                 w_timer_clear;
  logic                 w_done;
  logic                 w_accept;

  assign w_accept = (r_state == TX_IDLE) && Tx_start;

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  // Parity is frozen at capture so later Tx_data/Parity_odd changes cannot alter it.
  always_ff @(posedge Baud_Clk or negedge Reset) begin
    if (!Reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= (^Tx_data) ^ Parity_odd;
    end
  end
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = Parity_odd;
`endif

  // Every state entry restarts bit timing; IDLE holds the counter at zero.
  assign w_timer_clear = (w_state_next != r_state) || (r_state == TX_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (Baud_Clk),
    .rst_n     (Reset),
    .i_clear   (w_timer_clear),
    .o_bit_end (w_bit_end)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_done          = 1'b0;

    case (r_state)
      TX_IDLE: begin
        if (Tx_start) begin
          w_shift_next = Tx_data;
          w_state_next = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        if (w_bit_end) w_state_next = TX_DATA_BIT;
      end
      TX_DATA_BIT: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next   = TX_PARITY_BIT;
`else
            w_state_next   = TX_STOP_BIT;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        if (w_bit_end) w_state_next = TX_STOP_BIT;
      end
`endif
      TX_STOP_BIT: begin
        if (w_bit_end) begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            w_done          = 1'b1;
            w_stop_cnt_next = 1'b0;
            w_state_next    = TX_IDLE;
          end else begin
            w_stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next    = TX_IDLE;
        w_bit_cnt_next  = '0;
        w_stop_cnt_next = 1'b0;
      end
    endcase
  end

  // Line level is decoded from the next state so Tx_serial is a clean flop output.
  always_comb begin
    w_serial_next = 1'b1;
    case (w_state_next)
      TX_START_BIT:  w_serial_next = 1'b0;
      TX_DATA_BIT:   w_serial_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: w_serial_next = r_parity;
`endif
      default:       w_serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge Baud_Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= TX_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_serial   <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_serial   <= w_serial_next;
    end
  end

  assign Tx_ready  = (r_state == TX_IDLE);
  assign Tx_busy   = ~Tx_ready;
  assign Tx_done   = w_done;
  assign Tx_serial = r_serial;

endmodule
